// File: rtl/writeback_unit.sv
// writeback_unit: EX/WB pipeline register, write-back select, 8x8 register
// file with write-through read ports, and WB->EX forwarding control.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   EX_WB_*, ALU_out      instruction fields arriving from EX
//   EX_WB_flush           squash the instruction entering WB
//   EX_ID_Rs/Rd_out       operand addresses of the instruction in EX
//   ID_Rs/Rd_addr         decode read addresses
//   ID_Rsdata/ID_Rddata   decode read data (bypassed from WB)
//   WB_mux_out            write-back value of the instruction in WB
//   WB_Rd_out             destination of the instruction in WB
//   WB_regWrite_out       instruction in WB writes the register file
//   ctrl                  forwarding select: [0] Rs operand, [1] Rd operand
module writeback_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] EX_WB_Rsdata_in,
   input  logic [DATA_W-1:0] ALU_out,
   input  logic [ADDR_W-1:0] EX_WB_Rd_in,
   input  logic              EX_WB_write_mux_in,
   input  logic              EX_WB_regWrite_in,
   input  logic              EX_WB_flush,
   input  logic [ADDR_W-1:0] EX_ID_Rs_out,
   input  logic [ADDR_W-1:0] EX_ID_Rd_out,
   input  logic [ADDR_W-1:0] ID_Rs_addr,
   input  logic [ADDR_W-1:0] ID_Rd_addr,
   output logic [DATA_W-1:0] ID_Rsdata,
   output logic [DATA_W-1:0] ID_Rddata,
   output logic [DATA_W-1:0] WB_mux_out,
   output logic [ADDR_W-1:0] WB_Rd_out,
   output logic              WB_regWrite_out,
   output logic [1:0]        ctrl
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] rsdata_q;
   logic [DATA_W-1:0] alu_q;
   logic [ADDR_W-1:0] rd_q;
   logic              wmux_q;
   logic              regwrite_q;
   logic              regwrite_d;

   logic [DATA_W-1:0] rf_q [NREG];

   // A flush only kills the write enable; data fields load regardless.
   assign regwrite_d = EX_WB_regWrite_in & ~EX_WB_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsdata_q   <= '0;
         alu_q      <= '0;
         rd_q       <= '0;
         wmux_q     <= 1'b0;
         regwrite_q <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rsdata_q   <= EX_WB_Rsdata_in;
         alu_q      <= ALU_out;
         rd_q       <= EX_WB_Rd_in;
         wmux_q     <= EX_WB_write_mux_in;
         regwrite_q <= regwrite_d;
         // Commits the instruction already in WB, even if the
         // incoming one is being flushed.
         if (regwrite_q) begin
            rf_q[rd_q] <= WB_mux_out;
         end
      end
   end

   assign WB_mux_out      = wmux_q ? alu_q : rsdata_q;
   assign WB_Rd_out       = rd_q;
   assign WB_regWrite_out = regwrite_q;

   // Write-through: a read of the register being written this cycle
   // sees the new value before it commits.
   assign ID_Rsdata = (regwrite_q && (ID_Rs_addr == rd_q))
                    ? WB_mux_out : rf_q[ID_Rs_addr];
   assign ID_Rddata = (regwrite_q && (ID_Rd_addr == rd_q))
                    ? WB_mux_out : rf_q[ID_Rd_addr];

   assign ctrl[0] = regwrite_q & (rd_q == EX_ID_Rs_out);
   assign ctrl[1] = regwrite_q & (rd_q == EX_ID_Rd_out);

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized and directed checks of writeback_unit
// against a behavioural register-file / WB-slot model.
`timescale 1ns/100ps
module tb_writeback_unit;

   logic       clk;
   logic       rst_n;
   logic [7:0] rsdata_in;
   logic [7:0] alu_out;
   logic [2:0] rd_in;
   logic       wmux_in;
   logic       rw_in;
   logic       flush;
   logic [2:0] ex_rs;
   logic [2:0] ex_rd;
   logic [2:0] id_rs;
   logic [2:0] id_rd;
   logic [7:0] id_rsdata;
   logic [7:0] id_rddata;
   logic [7:0] wb_mux;
   logic [2:0] wb_rd;
   logic       wb_rw;
   logic [1:0] ctrl;

   int vectors;
   int miscompares;

   // Reference model: architectural registers plus the one instruction
   // sitting in WB (its final write-back value, target and enable).
   logic [7:0] m_rf [8];
   logic [7:0] m_val;
   logic [2:0] m_rd;
   logic       m_we;

   writeback_unit #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .EX_WB_Rsdata_in    (rsdata_in),
      .ALU_out            (alu_out),
      .EX_WB_Rd_in        (rd_in),
      .EX_WB_write_mux_in (wmux_in),
      .EX_WB_regWrite_in  (rw_in),
      .EX_WB_flush        (flush),
      .EX_ID_Rs_out       (ex_rs),
      .EX_ID_Rd_out       (ex_rd),
      .ID_Rs_addr         (id_rs),
      .ID_Rd_addr         (id_rd),
      .ID_Rsdata          (id_rsdata),
      .ID_Rddata          (id_rddata),
      .WB_mux_out         (wb_mux),
      .WB_Rd_out          (wb_rd),
      .WB_regWrite_out    (wb_rw),
      .ctrl               (ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_val = 8'h00;
      m_rd  = 3'd0;
      m_we  = 1'b0;
   endfunction

   function automatic logic [7:0] exp_read(input logic [2:0] a);
      if (m_we && a == m_rd) return m_val;
      return m_rf[a];
   endfunction

   function automatic logic [1:0] exp_ctrl(input logic [2:0] s,
                                           input logic [2:0] d);
      logic [1:0] c;
      c[0] = m_we && (m_rd == s);
      c[1] = m_we && (m_rd == d);
      return c;
   endfunction

   // Present one EX instruction, clock it in, advance the model, settle.
   task automatic apply(input logic [7:0] rs, input logic [7:0] alu,
                        input logic [2:0] rd, input logic wm,
                        input logic rw, input logic fl);
      rsdata_in = rs;
      alu_out   = alu;
      rd_in     = rd;
      wmux_in   = wm;
      rw_in     = rw;
      flush     = fl;
      @(posedge clk);
      if (m_we) m_rf[m_rd] = m_val;
      m_val = wm ? alu : rs;
      m_rd  = rd;
      m_we  = rw && !fl;
      #1;
   endtask

   task automatic nop();
      apply(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rsdata_in = 8'($urandom);
      alu_out   = 8'($urandom);
      rd_in     = 3'($urandom);
      wmux_in   = 1'b1;
      rw_in     = 1'b1;
      flush     = 1'b0;
      ex_rs     = 3'd0;
      ex_rd     = 3'd0;
      id_rs     = 3'd0;
      id_rd     = 3'd0;
      model_reset();
      #7;
      vectors++;
      if (wb_mux !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_wb_mux got %h want 00", wb_mux);
      end
      vectors++;
      if (wb_rw !== 1'b0 || wb_rd !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_wb_ctl got rw=%b rd=%0d want 0/0", wb_rw, wb_rd);
      end
      vectors++;
      if (ctrl !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_ctrl got %b want 00", ctrl);
      end
      rw_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         id_rs = 3'(i);
         id_rd = 3'(i + 4);
         #0.5;
         vectors++;
         if (id_rsdata !== 8'h00 || id_rddata !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_rf r%0d/r%0d got %h/%h want 00/00",
                     i, i + 4, id_rsdata, id_rddata);
         end
      end
   endtask

   task automatic test_shift_wb();
      apply(8'($urandom), 8'h28, 3'd3, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (wb_mux !== 8'h28 || wb_rd !== 3'd3 || wb_rw !== 1'b1) begin
         miscompares++;
         $display("FAIL shift_wb got %h/%0d/%b want 28/3/1",
                  wb_mux, wb_rd, wb_rw);
      end
      nop();
      id_rs = 3'd3;
      #1;
      vectors++;
      if (id_rsdata !== 8'h28) begin
         miscompares++;
         $display("FAIL shift_commit got %h want 28", id_rsdata);
      end
   endtask

   task automatic test_move_bypass();
      apply(8'h5A, 8'($urandom), 3'd6, 1'b0, 1'b1, 1'b0);
      id_rd = 3'd6;
      id_rs = 3'd6;
      #1;
      vectors++;
      if (id_rddata !== 8'h5A || id_rsdata !== 8'h5A) begin
         miscompares++;
         $display("FAIL move_bypass got %h/%h want 5a/5a",
                  id_rsdata, id_rddata);
      end
      nop();
      #1;
      vectors++;
      if (id_rddata !== 8'h5A) begin
         miscompares++;
         $display("FAIL move_commit got %h want 5a", id_rddata);
      end
   endtask

   task automatic test_forwarding();
      apply(8'h11, 8'h22, 3'd2, 1'b1, 1'b1, 1'b0);
      ex_rs = 3'd2;
      ex_rd = 3'd5;
      #1;
      vectors++;
      if (ctrl !== 2'b01) begin
         miscompares++;
         $display("FAIL fwd_rs got %b want 01", ctrl);
      end
      ex_rd = 3'd2;
      #1;
      vectors++;
      if (ctrl !== 2'b11) begin
         miscompares++;
         $display("FAIL fwd_both got %b want 11", ctrl);
      end
      apply(8'h11, 8'h22, 3'd2, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (ctrl !== 2'b00) begin
         miscompares++;
         $display("FAIL fwd_norw got %b want 00", ctrl);
      end
      // Register 0 forwards like any other register.
      apply(8'h33, 8'h44, 3'd0, 1'b1, 1'b1, 1'b0);
      ex_rs = 3'd1;
      ex_rd = 3'd0;
      #1;
      vectors++;
      if (ctrl !== 2'b10) begin
         miscompares++;
         $display("FAIL fwd_r0 got %b want 10", ctrl);
      end
   endtask

   task automatic test_flush();
      logic [7:0] old4;
      old4 = exp_read(3'd4);
      apply(8'hFF, 8'hFF, 3'd4, 1'b1, 1'b1, 1'b1);
      ex_rs = 3'd4;
      ex_rd = 3'd4;
      #1;
      vectors++;
      if (wb_rw !== 1'b0 || ctrl !== 2'b00) begin
         miscompares++;
         $display("FAIL flush_wb got rw=%b ctrl=%b want 0/00", wb_rw, ctrl);
      end
      nop();
      id_rs = 3'd4;
      #1;
      vectors++;
      if (id_rsdata !== old4) begin
         miscompares++;
         $display("FAIL flush_r4 got %h want %h", id_rsdata, old4);
      end
      // A pending write still commits on the edge that flushes the next.
      apply(8'h00, 8'hC3, 3'd5, 1'b1, 1'b1, 1'b0);
      apply(8'h99, 8'h99, 3'd7, 1'b1, 1'b1, 1'b1);
      id_rs = 3'd5;
      #1;
      vectors++;
      if (id_rsdata !== 8'hC3) begin
         miscompares++;
         $display("FAIL flush_pending got %h want c3", id_rsdata);
      end
   endtask

   task automatic test_reset_midop();
      apply(8'h00, 8'h77, 3'd1, 1'b1, 1'b1, 1'b0);
      ex_rs = 3'd1;
      ex_rd = 3'd1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (wb_mux !== 8'h00 || wb_rw !== 1'b0 || ctrl !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst_out got %h/%b/%b want 00/0/00",
                  wb_mux, wb_rw, ctrl);
      end
      rw_in = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      id_rs = 3'd1;
      #1;
      vectors++;
      if (id_rsdata !== 8'h00) begin
         miscompares++;
         $display("FAIL midrst_r1 got %h want 00", id_rsdata);
      end
   endtask

   task automatic test_random();
      logic [7:0] e;
      for (int n = 0; n < 300; n++) begin
         apply(8'($urandom), 8'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) == 0));
         ex_rs = 3'($urandom);
         ex_rd = 3'($urandom);
         id_rs = ($urandom_range(0, 2) == 0) ? m_rd : 3'($urandom);
         id_rd = ($urandom_range(0, 2) == 0) ? m_rd : 3'($urandom);
         #1;
         vectors++;
         if (wb_mux !== m_val || wb_rd !== m_rd || wb_rw !== m_we) begin
            miscompares++;
            $display("FAIL rnd_wb[%0d] got %h/%0d/%b want %h/%0d/%b",
                     n, wb_mux, wb_rd, wb_rw, m_val, m_rd, m_we);
         end
         vectors++;
         if (ctrl !== exp_ctrl(ex_rs, ex_rd)) begin
            miscompares++;
            $display("FAIL rnd_ctrl[%0d] got %b want %b",
                     n, ctrl, exp_ctrl(ex_rs, ex_rd));
         end
         e = exp_read(id_rs);
         vectors++;
         if (id_rsdata !== e) begin
            miscompares++;
            $display("FAIL rnd_rs[%0d] got %h want %h", n, id_rsdata, e);
         end
         e = exp_read(id_rd);
         vectors++;
         if (id_rddata !== e) begin
            miscompares++;
            $display("FAIL rnd_rd[%0d] got %h want %h", n, id_rddata, e);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_shift_wb();
      test_move_bypass();
      test_forwarding();
      test_flush();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Write-back end of the 8-bit shift/move pipeline, and the consumer of the EX→WB interface.
- Registers the EX/WB pipeline fields and selects the write-back value (WB_mux_out).
- Writes the 8x8 register file and serves two combinational ID read ports.
- Generates the 2-bit forwarding control (ctrl) that the execution stage uses to take WB_mux_out in place of stale operands.

Parameters:
DATA_W, 8, data/register width
ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
EX_WB_Rsdata_in  input  DATA_W  Rs data (possibly forwarded) from EX
ALU_out  input  DATA_W  shift result from EX
EX_WB_Rd_in  input  ADDR_W  destination register from EX
EX_WB_write_mux_in  input  1  1 = write ALU_out, 0 = write Rsdata (move)
EX_WB_regWrite_in  input  1  EX instruction writes a register
EX_WB_flush  input  1  squash the instruction entering WB
EX_ID_Rs_out  input  ADDR_W  Rs address of instruction currently in EX
EX_ID_Rd_out  input  ADDR_W  Rd address of instruction currently in EX
ID_Rs_addr  input  ADDR_W  register file read address A (decode)
ID_Rd_addr  input  ADDR_W  register file read address B (decode)
ID_Rsdata  output  DATA_W  read data A
ID_Rddata  output  DATA_W  read data B
WB_mux_out  output  DATA_W  write-back value of instruction in WB
WB_Rd_out  output  ADDR_W  destination of instruction in WB
WB_regWrite_out  output  1  instruction in WB writes register file
ctrl  output  2  forwarding select; [0] = Rs operand, [1] = Rd operand

Behaviour:
Pipeline register:
- Fields: wb_rsdata, wb_alu, wb_rd, wb_wmux, wb_regwrite.
- Loaded every rising clk edge from the EX_WB_* and ALU_out inputs.
- When EX_WB_flush=1 at the edge, wb_regwrite loads 0; the other fields still load.
- No stall; one instruction enters per cycle.

Write-back select:
- WB_mux_out = wb_alu when wb_wmux=1, else wb_rsdata.
- Combinational from the registered fields.
- WB_Rd_out = wb_rd; WB_regWrite_out = wb_regwrite.

Register file:
- 2**ADDR_W entries of DATA_W bits.
- On each rising edge with wb_regwrite=1, entry[wb_rd] <= WB_mux_out.
- Latency: EX inputs are captured at edge N. WB_mux_out is valid during cycle N+1. The register file is written at edge N+1.

Read ports:
- ID_Rsdata = entry[ID_Rs_addr] and ID_Rddata = entry[ID_Rd_addr], combinational.
- Write-through bypass: if wb_regwrite=1 and the read address equals wb_rd, the port returns WB_mux_out instead of the stored entry.
- The bypass applies to both ports independently, including when both addresses equal wb_rd.

Forwarding (combinational):
- ctrl[0] = wb_regwrite & (wb_rd == EX_ID_Rs_out).
- ctrl[1] = wb_regwrite & (wb_rd == EX_ID_Rd_out).
- Both bits may be 1 at once when Rs == Rd == wb_rd.
- A flushed WB instruction never forwards.
- Register 0 is an ordinary writable register and forwards normally.

Reset (asynchronous, active-low):
- rst_n=0 immediately clears all pipeline fields and all register file entries to 0.
- Consequences during reset: WB_mux_out=0, WB_Rd_out=0, WB_regWrite_out=0, ctrl=2'b00, ID_Rsdata=ID_Rddata=0.
- Reset asserted mid-operation discards the in-flight WB instruction with no register file write.
- The first edge after rst_n deasserts loads the pipeline register normally.

Simultaneous events:
- A write and a read of the same address in the same cycle: the read returns the new value via the bypass.
- A flush at the same edge as a pending write-back: the pending write (wb_regwrite from the previous edge) still commits. Only the incoming instruction is squashed.

Test Plan:
- Reset: drive arbitrary inputs with rst_n=0 → all outputs 0 and ctrl=00. After release, every register reads 0x00.
- Shift write-back: ALU_out=0x28, write_mux=1, Rd=3, regWrite=1 at edge N → WB_mux_out=0x28 in cycle N+1; after edge N+1, ID_Rs_addr=3 reads 0x28.
- Move write-back: Rsdata=0x5A, write_mux=0, Rd=6 → register 6 reads 0x5A. With ID_Rd_addr=6 in cycle N+1, bypass returns 0x5A before commit.
- Forwarding: WB holds Rd=2, regWrite=1; EX_ID_Rs_out=2, EX_ID_Rd_out=5 → ctrl=01. EX_ID_Rd_out=2 → ctrl=11. Same case with regWrite=0 → ctrl=00.
- Flush: EX_WB_flush=1 with regWrite=1, Rd=4, data 0xFF → WB_regWrite_out=0, ctrl=00, and register 4 keeps its old value.
- Reset mid-op: assert rst_n=0 between edges while WB holds a write to reg 1 → reg 1 remains 0x00 and outputs clear immediately.
